// File: rtl/arm_cpu_pkg.sv
// Shared CPU constants: default data-memory depth and the MMIO register map.
// Also provides the MMIO address decoder used by data_memory_mmio.
package arm_cpu_pkg;

   localparam int DATA_MEM_DEPTH = 64;

   localparam logic [31:0] MMIO_BASE      = 32'hFFFF_FF00;
   localparam logic [31:0] MMIO_CYCLE_OFS = 32'h0000_0000;
   localparam logic [31:0] MMIO_IO_OFS    = 32'h0000_0004;
   localparam logic [31:0] MMIO_STORE_OFS = 32'h0000_0008;

   typedef enum logic [1:0] {
      MMIO_NONE,
      MMIO_CYCLE,
      MMIO_IO,
      MMIO_STORE
   } mmio_reg_e;

   // The low two address bits are ignored so misaligned loads still see the register.
   function automatic mmio_reg_e mmio_decode(input logic [31:0] addr);
      logic [31:0] word_addr;
      word_addr = {addr[31:2], 2'b00};
      if (word_addr == MMIO_BASE + MMIO_CYCLE_OFS)      return MMIO_CYCLE;
      else if (word_addr == MMIO_BASE + MMIO_IO_OFS)    return MMIO_IO;
      else if (word_addr == MMIO_BASE + MMIO_STORE_OFS) return MMIO_STORE;
      else                                              return MMIO_NONE;
   endfunction

endpackage

// File: rtl/data_memory_mmio.sv
// Memory-mapped register block: free-running cycle counter, io_out register,
// and read-back of the store counter. Only built with DATA_MEMORY_MMIO_EN.
module data_memory_mmio
   import arm_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        mem_write,
   input  logic [31:0] write_data,
   input  logic [31:0] store_count,
   output logic [31:0] rd_data,
   output logic        hit,
   output logic        store_ok,
   output logic [31:0] io_out
);

   mmio_reg_e   sel;
   logic [31:0] cycle_count;

   assign sel      = mmio_decode(addr);
   assign hit      = (sel != MMIO_NONE);
   assign store_ok = mem_write && (addr[1:0] == 2'b00) && (sel == MMIO_IO);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_out <= '0;
      end else if (store_ok) begin
         io_out <= write_data;
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         MMIO_CYCLE: rd_data = cycle_count;
         MMIO_IO:    rd_data = io_out;
         MMIO_STORE: rd_data = store_count;
         default:    rd_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// CPU data memory: word RAM with combinational reads, store counter and illegal-store flag.
// Define DATA_MEMORY_MMIO_EN to add the MMIO block (cycle counter, io_out, store counter).
module data_memory
   import arm_cpu_pkg::*;
#(
   parameter int DEPTH = DATA_MEM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] data_memory_addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        addr_error,
   output logic [31:0] io_out
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] word_idx;
   logic          ram_hit;
   logic          ram_we;
   logic [31:0]   store_count;
   logic [31:0]   mmio_rdata;
   logic          mmio_hit;
   logic          mmio_store_ok;

   assign word_idx = data_memory_addr[AW+1:2];
   assign ram_hit  = (data_memory_addr[31:AW+2] == '0);
   assign ram_we   = mem_write && (data_memory_addr[1:0] == 2'b00) && ram_hit;

`ifdef DATA_MEMORY_MMIO_EN
   data_memory_mmio u_mmio (
      .clk         (clk),
      .reset       (reset),
      .addr        (data_memory_addr),
      .mem_write   (mem_write),
      .write_data  (write_data),
      .store_count (store_count),
      .rd_data     (mmio_rdata),
      .hit         (mmio_hit),
      .store_ok    (mmio_store_ok),
      .io_out      (io_out)
   );
`else
   // The store counter is still maintained but has no read path in this build.
   logic unused_store_count;
   assign unused_store_count = ^store_count;
   assign mmio_rdata    = '0;
   assign mmio_hit      = 1'b0;
   assign mmio_store_ok = 1'b0;
   assign io_out        = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (ram_we) begin
         ram[word_idx] <= write_data;
      end
   end

   // Saturates rather than wrapping so a long-running program never reads a small count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store_count <= '0;
      end else if (ram_we && (store_count != 32'hFFFF_FFFF)) begin
         store_count <= store_count + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_error <= 1'b0;
      end else begin
         addr_error <= mem_write && !(ram_we || mmio_store_ok);
      end
   end

   always_comb begin
      read_data = '0;
      if (ram_hit) begin
         read_data = ram[word_idx];
      end else if (mmio_hit) begin
         read_data = mmio_rdata;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory against a word-array reference model.
// Exercises the MMIO map as well when DATA_MEMORY_MMIO_EN is defined.
module tb_data_memory;

   localparam int DEPTH = 64;

   logic        clk;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_memory_addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        addr_error;
   logic [31:0] io_out;

   data_memory #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_write        (mem_write),
      .data_memory_addr (data_memory_addr),
      .write_data       (write_data),
      .read_data        (read_data),
      .addr_error       (addr_error),
      .io_out           (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        err;
      logic [31:0] io;
   } exp_t;

   exp_t expq[$];

   int checks = 0;
   int errors = 0;
   bit stim_done = 1'b0;

   // Reference model state, expressed as what the CPU should observe.
   logic [31:0] mdl_ram [DEPTH];
   logic [31:0] mdl_cycles;
   logic [31:0] mdl_stores;
   logic [31:0] mdl_io;
   logic        mdl_err;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mdl_ram[i] = '0;
      mdl_cycles = '0;
      mdl_stores = '0;
      mdl_io     = '0;
      mdl_err    = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a < 32'(4 * DEPTH)) return mdl_ram[int'(a >> 2)];
`ifdef DATA_MEMORY_MMIO_EN
      case (a & ~32'h3)
         32'hFFFF_FF00: return mdl_cycles;
         32'hFFFF_FF04: return mdl_io;
         32'hFFFF_FF08: return mdl_stores;
         default:       return 32'h0;
      endcase
`else
      return 32'h0;
`endif
   endfunction

   task automatic checkOutput(input string name, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s %s: got %h, expected %h", name, what, act, exp);
      end
   endtask

   // Drives one cycle at the falling edge, queues what the CPU should see before
   // the next rising edge, then advances the model across that edge.
   task automatic applyStimulus(input string name, input logic rst, input logic we,
                                input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      bit   legal;
      @(negedge clk);
      reset            = rst;
      mem_write        = we;
      data_memory_addr = a;
      write_data       = wd;
      e.name = name;
      if (!rst) begin
         model_clear();
         e.rd  = '0;
         e.err = 1'b0;
         e.io  = '0;
         expq.push_back(e);
      end else begin
         e.rd  = model_read(a);
         e.err = mdl_err;
         e.io  = mdl_io;
         expq.push_back(e);
         legal = 1'b0;
         if (we && (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH))) begin
            mdl_ram[int'(a >> 2)] = wd;
            if (mdl_stores != 32'hFFFF_FFFF) mdl_stores = mdl_stores + 1;
            legal = 1'b1;
         end
`ifdef DATA_MEMORY_MMIO_EN
         if (we && (a == 32'hFFFF_FF04)) begin
            mdl_io = wd;
            legal  = 1'b1;
         end
`endif
         mdl_err    = we && !legal;
         mdl_cycles = mdl_cycles + 1;
      end
   endtask

   // Monitor: samples between edges and scores against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput(e.name, "read_data", read_data, e.rd);
            checkOutput(e.name, "addr_error", {31'h0, addr_error}, {31'h0, e.err});
            checkOutput(e.name, "io_out", io_out, e.io);
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic        we;
      logic        rst;
      int unsigned sel;
      reset = 1'b0;
      mem_write = 1'b0;
      data_memory_addr = '0;
      write_data = '0;
      model_clear();

      applyStimulus("reset_hold", 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus("reset_hold2", 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
      applyStimulus("reset_release", 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus("store7_pre", 1'b1, 1'b1, 32'h0000_00FC, 32'h7);
      applyStimulus("store7_post", 1'b1, 1'b0, 32'h0000_00FC, 32'h0);
      applyStimulus("misalign_store", 1'b1, 1'b1, 32'h0000_0002, 32'h1234_5678);
      applyStimulus("misalign_flag", 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      applyStimulus("misalign_clear", 1'b1, 1'b0, 32'h0000_0002, 32'h0);
      applyStimulus("unmapped_store", 1'b1, 1'b1, 32'h0000_0100, 32'h5555_AAAA);
      applyStimulus("unmapped_load", 1'b1, 1'b0, 32'h0000_0100, 32'h0);
      applyStimulus("misalign_load", 1'b1, 1'b0, 32'h0000_00FE, 32'h0);
      applyStimulus("io_store", 1'b1, 1'b1, 32'hFFFF_FF04, 32'hA5A5_A5A5);
      applyStimulus("io_after", 1'b1, 1'b0, 32'hFFFF_FF04, 32'h0);
      applyStimulus("ro_store", 1'b1, 1'b1, 32'hFFFF_FF00, 32'h1);
      applyStimulus("ro_flag", 1'b1, 1'b0, 32'hFFFF_FF08, 32'h0);
      applyStimulus("mid_reset", 1'b0, 1'b1, 32'h0000_00FC, 32'h9);
      applyStimulus("mid_reset_rel", 1'b1, 1'b0, 32'h0000_00FC, 32'h0);
      for (int i = 0; i < 9; i++) applyStimulus("idle", 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus("cycle_count10", 1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);

      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            5:             a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            6:             a = 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
            7:             a = 32'hFFFF_FF00 + (32'($urandom_range(0, 3)) << 2);
            8:             a = $urandom;
            default:       a = 32'hFFFF_FF04 | 32'($urandom_range(0, 3));
         endcase
         we  = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 79) != 0);
         applyStimulus("rand", rst, we, a, $urandom);
      end
      applyStimulus("final", 1'b1, 1'b0, 32'h0, 32'h0);

      for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
      #5;
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      stim_done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit RAM words (power of two, 4..1024).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-004 SHALL have port mem_write  input  1  store strobe from CPU, sampled at rising clk.
REQ-005 SHALL have port data_memory_addr  input  32  byte address from CPU ALU result.
REQ-006 SHALL have port write_data  input  32  store data from CPU.
REQ-007 SHALL have port read_data  output  32  load data to CPU, combinational.
REQ-008 SHALL have port addr_error  output  1  registered, high for one cycle after an illegal access.
REQ-009 SHALL have port io_out  output  32  registered MMIO output register value.

Function
REQ-010 SHALL map RAM at byte addresses 0 .. 4*DEPTH-1, word index = data_memory_addr[log2(DEPTH)+1:2].
REQ-011 SHALL drive read_data combinationally from current contents; a store in cycle N is visible on read_data only after the rising edge ending cycle N.
REQ-012 SHALL write RAM at rising clk when mem_write=1, address aligned (addr[1:0]=0) and in RAM range.
REQ-013 SHALL treat misaligned addresses (addr[1:0]!=0) with mem_write=1 as illegal: no state change, addr_error=1 for the following cycle.
REQ-014 SHALL treat addresses outside RAM and outside enabled MMIO as unmapped: read_data=0; store ignored and flagged via addr_error.
REQ-015 SHALL not flag loads; read_data for misaligned in-range addresses returns the containing word (addr[1:0] ignored).
REQ-016 SHALL count accepted RAM stores in a 32-bit store counter that saturates at 32'hffffffff.
REQ-017 SHALL keep a 32-bit cycle counter incrementing every clk out of reset, wrapping ffffffff -> 0.
REQ-018 SHALL leave RAM, counters and io_out unchanged on rejected stores.

Reset
REQ-019 SHALL on reset=0 set read_data source RAM to all zero, addr_error=0, io_out=0, cycle counter=0, store counter=0.
REQ-020 SHALL abort any store coincident with reset assertion; first counted cycle is the first rising edge with reset=1.

Configuration
REQ-021 SHALL with DATA_MEMORY_MMIO_EN defined map: 0xFFFFFF00 cycle counter (read-only), 0xFFFFFF04 io_out (R/W), 0xFFFFFF08 store counter (read-only).
REQ-022 SHALL with DATA_MEMORY_MMIO_EN defined treat stores to read-only MMIO as illegal (addr_error pulse, no change); store to 0xFFFFFF04 updates io_out at rising clk and is not counted.
REQ-023 SHALL without DATA_MEMORY_MMIO_EN treat 0xFFFFFF00-0xFFFFFF08 as unmapped, tie io_out=0, omit the cycle counter; store counter remains but is unreadable.

Structure
REQ-024 SHALL take MMIO base/offset constants and the default DEPTH from the shared package arm_cpu_pkg.
REQ-025 SHALL place MMIO decode, counters and io_out in sub-module data_memory_mmio, instantiated only under DATA_MEMORY_MMIO_EN.

Verification
REQ-026 Reset then addr 0x0, no store -> read_data=0, addr_error=0, io_out=0.
REQ-027 Store 7 to addr 0xff... aligned 0x00fc with mem_write=1 -> before edge read_data=0; after edge read_data=7; store counter=1.
REQ-028 Store to addr 0x0002 -> RAM word 0 unchanged, addr_error=1 for exactly one cycle, store counter unchanged.
REQ-029 Store to addr 0x00000100 (DEPTH=64, unmapped) -> no write, addr_error pulse, load of same address returns 0.
REQ-030 MMIO_EN: store 0xa5a5a5a5 to 0xFFFFFF04 -> io_out=a5a5a5a5 after edge; read 0xFFFFFF00 after 10 cycles from reset release -> 10; store to 0xFFFFFF00 -> addr_error pulse.
REQ-031 Assert reset=0 mid-sequence between clk edges -> io_out, counters, RAM and addr_error zero immediately, before next edge.
